// File: rtl/pipe_pkg.sv
// Shared fetch/decode definitions: redirect encodings, NOP, default reset PC
// and the fetch-queue entry layout.
package pipe_pkg;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // 2'b11 is treated as sequential, so only the two defined codes redirect.
    function automatic logic is_redirect(input logic [1:0] pcsrc);
        return (pcsrc == PCSRC_BRANCH) || (pcsrc == PCSRC_JUMP);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer: pushes exactly two entries, pops zero to two,
// and flushes to empty in one edge. Callers keep pops <= count and
// count + 2 <= DEPTH when pushing.
module fetch_queue
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  fetch_entry_t    push_entry_0_i,
    input  fetch_entry_t    push_entry_1_i,
    input  logic [1:0]      pop_cnt_i,
    output logic [CntW-1:0] count_o,
    output fetch_entry_t    head_0_o,
    output fetch_entry_t    head_1_o
);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    // Next pointers, count and storage; flush wins over push and pop.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) begin
                mem_d[tail_q]              = push_entry_0_i;
                mem_d[tail_q + PtrW'(1)]   = push_entry_1_i;
                tail_d                     = tail_q + PtrW'(2);
            end
            head_d  = head_q + PtrW'(pop_cnt_i);
            count_d = count_q + (push_i ? CntW'(2) : CntW'(0)) - CntW'(pop_cnt_i);
        end
    end

    // State update with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign count_o  = count_q;
    assign head_0_o = mem_q[head_q];
    assign head_1_o = mem_q[head_q + PtrW'(1)];

endmodule

// File: rtl/fetch_pair.sv
// Dual-issue fetch stage: requests two words per access, buffers them in a
// small queue and hands up to two instructions per cycle into the F/D
// registers. Decode redirects flush everything younger than D.
module fetch_pair
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic [1:0]  pcsrc_d_0,
    input  logic [1:0]  pcsrc_d_1,
    input  logic [31:0] pc_branch_d_0,
    input  logic [31:0] pc_branch_d_1,
    input  logic [31:0] pc_jump_d_0,
    input  logic [31:0] pc_jump_d_1,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata_0,
    input  logic [31:0] imem_rdata_1,
    output logic [31:0] instr_d_0,
    output logic [31:0] instr_d_1,
    output logic [31:0] pc_plus_8_d_0,
    output logic [31:0] pc_plus_8_d_1,
    output logic        valid_d_0,
    output logic        valid_d_1
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned OccW = CntW + 1;
    localparam logic [OccW-1:0] OccLimit = OccW'(DEPTH - 2);

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic        epoch_q, epoch_d;
    logic        req_epoch_q, req_epoch_d;
    logic [31:0] req_pc_q, req_pc_d;

    logic [31:0] instr_d_0_q, instr_d_0_d;
    logic [31:0] instr_d_1_q, instr_d_1_d;
    logic [31:0] pc_plus_8_d_0_q, pc_plus_8_d_0_d;
    logic [31:0] pc_plus_8_d_1_q, pc_plus_8_d_1_d;
    logic        valid_d_0_q, valid_d_0_d;
    logic        valid_d_1_q, valid_d_1_d;

    logic            redirect;
    logic [31:0]     redirect_pc;
    logic [CntW-1:0] q_count;
    logic [OccW-1:0] occupancy;
    logic            req_fire;
    logic            resp_live;
    logic [1:0]      pop_cnt;
    fetch_entry_t    head_0, head_1;
    fetch_entry_t    push_entry_0, push_entry_1;

    // Redirect decode; slot 0 is older and takes priority.
    always_comb begin
        redirect    = is_redirect(pcsrc_d_0) || is_redirect(pcsrc_d_1);
        redirect_pc = pc_q;
        if (is_redirect(pcsrc_d_0)) begin
            redirect_pc = (pcsrc_d_0 == PCSRC_BRANCH) ? pc_branch_d_0 : pc_jump_d_0;
        end else if (is_redirect(pcsrc_d_1)) begin
            redirect_pc = (pcsrc_d_1 == PCSRC_BRANCH) ? pc_branch_d_1 : pc_jump_d_1;
        end
    end

    // Request gating: reserve room for the pair still in flight.
    always_comb begin
        occupancy = OccW'(q_count) + (inflight_q ? OccW'(2) : OccW'(0));
        req_fire  = !reset && !redirect && (occupancy <= OccLimit);
        imem_en   = req_fire;
        imem_addr = pc_q;
    end

    // Response acceptance and dequeue sizing.
    always_comb begin
        // A response from an older epoch, or one landing in a redirect cycle, is dropped.
        resp_live    = inflight_q && (req_epoch_q == epoch_q) && !redirect;
        push_entry_0 = '{instr: imem_rdata_0, pc: req_pc_q};
        push_entry_1 = '{instr: imem_rdata_1, pc: req_pc_q + 32'd4};
        pop_cnt      = 2'd0;
        if (!stall_d && !redirect) begin
            pop_cnt = (q_count >= CntW'(2)) ? 2'd2 : q_count[1:0];
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk_i         (clk),
        .reset_i       (reset),
        .flush_i       (redirect),
        .push_i        (resp_live),
        .push_entry_0_i(push_entry_0),
        .push_entry_1_i(push_entry_1),
        .pop_cnt_i     (pop_cnt),
        .count_o       (q_count),
        .head_0_o      (head_0),
        .head_1_o      (head_1)
    );

    // Next PC, in-flight tracking and F/D register contents.
    always_comb begin
        pc_d        = pc_q;
        inflight_d  = req_fire;
        epoch_d     = epoch_q;
        req_epoch_d = req_epoch_q;
        req_pc_d    = req_pc_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            epoch_d = ~epoch_q;
        end else if (req_fire) begin
            pc_d        = pc_q + 32'd8;
            req_pc_d    = pc_q;
            req_epoch_d = epoch_q;
        end

        instr_d_0_d     = instr_d_0_q;
        instr_d_1_d     = instr_d_1_q;
        pc_plus_8_d_0_d = pc_plus_8_d_0_q;
        pc_plus_8_d_1_d = pc_plus_8_d_1_q;
        valid_d_0_d     = valid_d_0_q;
        valid_d_1_d     = valid_d_1_q;
        if (!stall_d) begin
            instr_d_0_d     = NOP_INSTR;
            instr_d_1_d     = NOP_INSTR;
            pc_plus_8_d_0_d = 32'h0;
            pc_plus_8_d_1_d = 32'h0;
            valid_d_0_d     = 1'b0;
            valid_d_1_d     = 1'b0;
            if (pop_cnt != 2'd0) begin
                instr_d_0_d     = head_0.instr;
                pc_plus_8_d_0_d = head_0.pc + 32'd8;
                valid_d_0_d     = 1'b1;
            end
            if (pop_cnt == 2'd2) begin
                instr_d_1_d     = head_1.instr;
                pc_plus_8_d_1_d = head_1.pc + 32'd8;
                valid_d_1_d     = 1'b1;
            end
        end
    end

    // Fetch state and F/D registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            inflight_q      <= 1'b0;
            epoch_q         <= 1'b0;
            req_epoch_q     <= 1'b0;
            req_pc_q        <= 32'h0;
            instr_d_0_q     <= NOP_INSTR;
            instr_d_1_q     <= NOP_INSTR;
            pc_plus_8_d_0_q <= 32'h0;
            pc_plus_8_d_1_q <= 32'h0;
            valid_d_0_q     <= 1'b0;
            valid_d_1_q     <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            epoch_q         <= epoch_d;
            req_epoch_q     <= req_epoch_d;
            req_pc_q        <= req_pc_d;
            instr_d_0_q     <= instr_d_0_d;
            instr_d_1_q     <= instr_d_1_d;
            pc_plus_8_d_0_q <= pc_plus_8_d_0_d;
            pc_plus_8_d_1_q <= pc_plus_8_d_1_d;
            valid_d_0_q     <= valid_d_0_d;
            valid_d_1_q     <= valid_d_1_d;
        end
    end

    assign instr_d_0     = instr_d_0_q;
    assign instr_d_1     = instr_d_1_q;
    assign pc_plus_8_d_0 = pc_plus_8_d_0_q;
    assign pc_plus_8_d_1 = pc_plus_8_d_1_q;
    assign valid_d_0     = valid_d_0_q;
    assign valid_d_1     = valid_d_1_q;

endmodule

// File: tb/tb_fetch_pair.sv
// Bench for fetch_pair: a queue-based reference model checks every cycle, a
// vector table covers reset release, and directed sequences cover stall,
// redirect and reset corners before a randomized run.
module tb_fetch_pair;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset, stall_d;
    logic [1:0]  pcsrc_d_0, pcsrc_d_1;
    logic [31:0] pc_branch_d_0, pc_branch_d_1, pc_jump_d_0, pc_jump_d_1;
    logic        imem_en;
    logic [31:0] imem_addr, imem_rdata_0, imem_rdata_1;
    logic [31:0] instr_d_0, instr_d_1, pc_plus_8_d_0, pc_plus_8_d_1;
    logic        valid_d_0, valid_d_1;

    always #5 clk = ~clk;

    fetch_pair #(
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_d      (stall_d),
        .pcsrc_d_0    (pcsrc_d_0),
        .pcsrc_d_1    (pcsrc_d_1),
        .pc_branch_d_0(pc_branch_d_0),
        .pc_branch_d_1(pc_branch_d_1),
        .pc_jump_d_0  (pc_jump_d_0),
        .pc_jump_d_1  (pc_jump_d_1),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_rdata_0 (imem_rdata_0),
        .imem_rdata_1 (imem_rdata_1),
        .instr_d_0    (instr_d_0),
        .instr_d_1    (instr_d_1),
        .pc_plus_8_d_0(pc_plus_8_d_0),
        .pc_plus_8_d_1(pc_plus_8_d_1),
        .valid_d_0    (valid_d_0),
        .valid_d_1    (valid_d_1)
    );

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2010_0004;
        if (a == 32'h4) return 32'h2011_0004;
        return {~a[15:0], a[15:0]};
    endfunction

    // Synchronous memory: words valid the cycle after the request.
    logic [31:0] rd_addr = 32'h0;
    always @(posedge clk) if (imem_en) rd_addr <= imem_addr;
    assign imem_rdata_0 = mem_word(rd_addr);
    assign imem_rdata_1 = mem_word(rd_addr + 32'd4);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program-order queue of {instr, pc} plus one pending response.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] e_i0, e_i1, e_p0, e_p1;
    logic        e_v0, e_v1;

    function automatic bit is_rd(input logic [1:0] s);
        return (s == 2'b01) || (s == 2'b10);
    endfunction

    function automatic bit m_redirect();
        return is_rd(pcsrc_d_0) || is_rd(pcsrc_d_1);
    endfunction

    function automatic bit m_req();
        int occ;
        occ = m_q.size() + (m_pend ? 2 : 0);
        return !reset && !m_redirect() && (occ <= int'(DEPTH) - 2);
    endfunction

    function automatic logic [31:0] m_target();
        if (is_rd(pcsrc_d_0)) return (pcsrc_d_0 == 2'b01) ? pc_branch_d_0 : pc_jump_d_0;
        return (pcsrc_d_1 == 2'b01) ? pc_branch_d_1 : pc_jump_d_1;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_pc   = 32'h0;
        m_pend = 1'b0;
        m_pend_pc = 32'h0;
        {e_i0, e_i1, e_p0, e_p1} = '0;
        {e_v0, e_v1} = '0;
    endtask

    task automatic sample_and_check();
        @(negedge clk);
        chk("imem_en", 32'(imem_en), 32'(m_req()));
        if (m_req()) chk("imem_addr", imem_addr, m_pc);
        chk("instr_d_0", instr_d_0, e_i0);
        chk("instr_d_1", instr_d_1, e_i1);
        chk("pc_plus_8_d_0", pc_plus_8_d_0, e_p0);
        chk("pc_plus_8_d_1", pc_plus_8_d_1, e_p1);
        chk("valid_d_0", 32'(valid_d_0), 32'(e_v0));
        chk("valid_d_1", 32'(valid_d_1), 32'(e_v1));
    endtask

    task automatic advance();
        bit redir, req;
        ent_t e;
        redir = m_redirect();
        req   = m_req();
        if (reset) begin
            m_reset();
        end else begin
            if (!stall_d) begin
                {e_i0, e_i1, e_p0, e_p1} = '0;
                {e_v0, e_v1} = '0;
                if (!redir && m_q.size() > 0) begin
                    e = m_q.pop_front();
                    e_i0 = e.instr; e_p0 = e.pc + 32'd8; e_v0 = 1'b1;
                end
                if (!redir && m_q.size() > 0) begin
                    e = m_q.pop_front();
                    e_i1 = e.instr; e_p1 = e.pc + 32'd8; e_v1 = 1'b1;
                end
            end
            if (m_pend && !redir) begin
                m_q.push_back('{instr: mem_word(m_pend_pc), pc: m_pend_pc});
                m_q.push_back('{instr: mem_word(m_pend_pc + 32'd4), pc: m_pend_pc + 32'd4});
            end
            if (redir) begin
                m_q.delete();
                m_pc   = m_target();
                m_pend = 1'b0;
            end else if (req) begin
                m_pend    = 1'b1;
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd8;
            end else begin
                m_pend = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample_and_check();
        advance();
    endtask

    typedef struct {
        logic        stall;
        logic        en;
        logic [31:0] addr;
        logic        v0, v1;
        logic [31:0] i0, i1, p0, p1;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        bit   found;
        bit   stall_pat[10];

        vecs[0] = '{0, 1, 32'd0,  0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1] = '{0, 1, 32'd8,  0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[2] = '{0, 1, 32'd16, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[3] = '{0, 1, 32'd24, 1, 1, 32'h2010_0004, 32'h2011_0004, 32'd8, 32'd12};
        vecs[4] = '{0, 1, 32'd32, 1, 1, 32'hFFF7_0008, 32'hFFF3_000C, 32'd16, 32'd20};
        stall_pat = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 0};

        reset = 1'b1; stall_d = 1'b0;
        pcsrc_d_0 = 2'b00; pcsrc_d_1 = 2'b00;
        pc_branch_d_0 = 32'h0; pc_branch_d_1 = 32'h0;
        pc_jump_d_0 = 32'h0; pc_jump_d_1 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        step();  // reset still high: imem_en low, D cleared
        reset = 1'b0;

        // Reset release and warm-up.
        for (int i = 0; i < 5; i++) begin
            stall_d = vecs[i].stall;
            sample_and_check();
            chk($sformatf("vec%0d_en", i), 32'(imem_en), 32'(vecs[i].en));
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("vec%0d_v0", i), 32'(valid_d_0), 32'(vecs[i].v0));
            chk($sformatf("vec%0d_v1", i), 32'(valid_d_1), 32'(vecs[i].v1));
            chk($sformatf("vec%0d_i0", i), instr_d_0, vecs[i].i0);
            chk($sformatf("vec%0d_i1", i), instr_d_1, vecs[i].i1);
            chk($sformatf("vec%0d_p0", i), pc_plus_8_d_0, vecs[i].p0);
            chk($sformatf("vec%0d_p1", i), pc_plus_8_d_1, vecs[i].p1);
            advance();
        end

        // Branch while a response is in flight.
        pcsrc_d_0 = 2'b01; pc_branch_d_0 = 32'h100;
        step();
        pcsrc_d_0 = 2'b00;
        sample_and_check();
        chk("br_en", 32'(imem_en), 32'd1);
        chk("br_addr", imem_addr, 32'h100);
        advance();
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            sample_and_check();
            if (valid_d_0 === 1'b1) begin
                chk("br_first_pc8", pc_plus_8_d_0, 32'h108);
                found = 1'b1;
            end
            advance();
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL br_timeout: no valid pair after branch, required one within 8 cycles");
        end

        // Jump in slot 0 beats branch in slot 1.
        pcsrc_d_0 = 2'b10; pc_jump_d_0 = 32'h200;
        pcsrc_d_1 = 2'b01; pc_branch_d_1 = 32'h300;
        step();
        pcsrc_d_0 = 2'b00; pcsrc_d_1 = 2'b00;
        sample_and_check();
        chk("prio_addr", imem_addr, 32'h200);
        advance();
        repeat (4) step();

        // Stall long enough to fill the queue, then drain in order.
        stall_d = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_and_check();
            if (i == 4) chk("stall_full_en", 32'(imem_en), 32'd0);
            advance();
        end
        stall_d = 1'b0;
        repeat (10) step();

        // Redirect to 0x40 followed by stall pulses.
        pcsrc_d_0 = 2'b01; pc_branch_d_0 = 32'h40;
        step();
        pcsrc_d_0 = 2'b00;
        for (int i = 0; i < 10; i++) begin
            stall_d = stall_pat[i];
            step();
        end
        stall_d = 1'b0;

        // Reset mid-stream.
        reset = 1'b1;
        sample_and_check();
        chk("rst_en", 32'(imem_en), 32'd0);
        advance();
        reset = 1'b0;
        sample_and_check();
        chk("rst_i0", instr_d_0, 32'h0);
        chk("rst_i1", instr_d_1, 32'h0);
        chk("rst_p0", pc_plus_8_d_0, 32'h0);
        chk("rst_p1", pc_plus_8_d_1, 32'h0);
        chk("rst_v0", 32'(valid_d_0), 32'd0);
        chk("rst_v1", 32'(valid_d_1), 32'd0);
        advance();

        // Randomized traffic, including 2'b11 codes and PC wrap targets.
        for (int i = 0; i < 400; i++) begin
            int r0, r1;
            stall_d = ($urandom_range(99) < 30);
            r0 = $urandom_range(99);
            r1 = $urandom_range(99);
            pcsrc_d_0 = (r0 < 5) ? 2'b01 : (r0 < 9) ? 2'b10 : (r0 < 14) ? 2'b11 : 2'b00;
            pcsrc_d_1 = (r1 < 5) ? 2'b01 : (r1 < 9) ? 2'b10 : (r1 < 14) ? 2'b11 : 2'b00;
            pc_branch_d_0 = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFC);
            pc_branch_d_1 = $urandom() & 32'hFFFF_FFFC;
            pc_jump_d_0   = $urandom() & 32'hFFFC;
            pc_jump_d_1   = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFC);
            reset = ($urandom_range(199) == 0);
            step();
        end
        reset = 1'b0; stall_d = 1'b0; pcsrc_d_0 = 2'b00; pcsrc_d_1 = 2'b00;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pair.md
Name: fetch_pair

Overview:
- Dual-issue fetch stage. Produces the instruction pair and PC+8 values that the dual decode stage consumes: instr_d_0/1 and pc_plus_8_d_0/1.
- Fetches two consecutive words per request from a synchronous instruction memory and buffers them in a small queue.
- Hands up to two instructions per cycle into the F/D pipeline registers.
- Redirects on branch/jump resolution from decode (pcsrc_d_0/1, pc_branch_d_0/1, pc_jump_d_0/1).

Parameters:
- DEPTH, 4, queue entries (instructions); power of two, >= 4
- RESET_PC, 32'h00000000, first fetch address after reset

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- stall_d  input  1  hold F/D registers and queue head (from hazard unit)
- pcsrc_d_0  input  2  slot-0 redirect: 00 seq, 01 branch, 10 jump, 11 treated as 00
- pcsrc_d_1  input  2  slot-1 redirect, same encoding
- pc_branch_d_0, pc_branch_d_1  input  32  branch targets
- pc_jump_d_0, pc_jump_d_1  input  32  jump targets
- imem_en  output  1  read request this cycle
- imem_addr  output  32  word address of first word; the second word is imem_addr+4
- imem_rdata_0, imem_rdata_1  input  32  words at addr and addr+4, valid the cycle after imem_en
- instr_d_0, instr_d_1  output  32  F/D instruction registers
- pc_plus_8_d_0, pc_plus_8_d_1  output  32  pc+8 of each slot (slot 1 = slot 0 + 4 when both come from one pair)
- valid_d_0, valid_d_1  output  1  slot holds a real instruction

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_PC, queue count=0, inflight=0.
  - instr_d_*=32'h0 (NOP), pc_plus_8_d_*=0, valid_d_*=0.
  - imem_en=0 while reset is high.
  - Reset asserted mid-operation discards the queue, any in-flight response and the D contents on the next edge.
- Request (combinational from state):
  - imem_en = !reset && !redirect && (count + 2*inflight) <= DEPTH-2.
  - imem_addr = pc.
  - On an accepted request: pc += 8 and inflight=1 at the edge.
- Response:
  - Arrives one cycle after the request.
  - If not killed, push {imem_rdata_0, pc_req} then {imem_rdata_1, pc_req+4} into the queue (2 entries).
  - inflight clears.
- Dequeue (when !stall_d and !redirect):
  - pop min(count, 2) entries.
  - count >= 2: slot0=head, slot1=head+1, both valid.
  - count == 1: slot0=head valid; slot1=NOP, valid_d_1=0.
  - count == 0: both slots NOP, valid 0.
  - pc_plus_8 = entry pc + 8.
- No bypass: a response reaches D no earlier than one cycle after it is enqueued.
- Simultaneous push and pop in the same cycle is legal. The new count is count+2-pops and never exceeds DEPTH, guaranteed by the request rule.
- stall_d without redirect:
  - F/D registers and queue head hold.
  - Responses still enqueue.
  - Requests continue while space allows.
- Redirect (combinational):
  - redirect = (pcsrc_d_0 is 01/10) || (pcsrc_d_1 is 01/10).
  - Slot 0 has priority. Target: 01 → pc_branch_d_x, 10 → pc_jump_d_x.
  - At the edge: pc=target, count=0, and the in-flight response is marked killed (epoch bit toggles; a response tagged with the old epoch is dropped). No request is issued in a redirect cycle.
  - If !stall_d: D registers load NOP, valid 0.
  - If stall_d: D registers hold.
- Wrap-around: head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. The PC wraps modulo 2^32.
- Delay-slot handling of slot 1 after a slot-0 redirect is owned by the hazard/decode logic. This block only flushes what is younger than D.
- Latency from reset release, cycle 0 = first cycle with reset low:
  - cycle 0: imem_en=1, addr=RESET_PC
  - cycle 1: response enqueued
  - cycle 3: D outputs show the pair
  - Same timing after a redirect edge.

Decomposition:
- Shared package pipe_pkg holds:
  - PCSRC_SEQ/PCSRC_BRANCH/PCSRC_JUMP encodings
  - NOP_INSTR=32'h0
  - RESET_PC default
  - the queue-entry struct {instr[31:0], pc[31:0]}
- One sub-module: fetch_queue, a 2-push/2-pop circular buffer with count, head/tail pointers and flush. fetch_pair holds the PC, the inflight/epoch flags and the F/D registers.

Test Plan:
- Reset release, imem word@0=32'h20100004, word@4=32'h20110004 → cycle 3: instr_d_0=20100004, instr_d_1=20110004, pc_plus_8_d_0=8, pc_plus_8_d_1=12, both valid.
- Steady flow with no stall → a new pair every cycle after warm-up; imem_addr sequence 0,8,16,24; pc_plus_8_d_0 increments by 8 each cycle.
- stall_d held 5 cycles → D outputs constant; the queue fills to DEPTH and imem_en drops to 0; after release, pairs resume in order with no loss or duplication.
- pcsrc_d_0=01, pc_branch_d_0=32'h100 while a response is in flight → the in-flight words are dropped, imem_addr=32'h100 the next cycle, and the next valid D pair has pc_plus_8_d_0=32'h108.
- Same cycle: pcsrc_d_0=10 (pc_jump_d_0=32'h200) and pcsrc_d_1=01 (pc_branch_d_1=32'h300) → the redirect goes to 32'h200.
- Odd count: redirect to 32'h40, then stall_d is pulsed so a single entry remains → valid_d_0=1, valid_d_1=0, instr_d_1=0; reset asserted mid-stream → all outputs return to zero on the next edge.
